// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready handshake and registered zr/ng/cout/ovf flags.
// Stage 1 conditions the operands; stage 2 computes the result and its status flags.
module hack_alu_pipe #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             cout,
   output logic             ovf
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y;
   logic             s1_f;
   logic             s1_no;

   logic             s2_ready;
   logic             accept;
   logic             advance;

   logic [WIDTH-1:0] x_pre;
   logic [WIDTH-1:0] y_pre;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             res_cout;
   logic             res_ovf;

   // in_ready depends combinationally on out_ready so a full pipe can still
   // take a new operation in the same cycle the consumer drains it.
   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;
   assign accept   = in_valid && in_ready;
   assign advance  = s1_valid && s2_ready;

   always_comb begin
      x_pre = zx ? '0 : a;
      if (nx) x_pre = ~x_pre;
      y_pre = zy ? '0 : b;
      if (ny) y_pre = ~y_pre;
   end

   always_comb begin
      sum      = {1'b0, s1_x} + {1'b0, s1_y};
      res      = s1_f ? sum[WIDTH-1:0] : (s1_x & s1_y);
      if (s1_no) res = ~res;
      res_cout = s1_f & sum[WIDTH];
      // overflow is judged on the raw sum, before the optional final inversion
      res_ovf  = s1_f & (s1_x[WIDTH-1] == s1_y[WIDTH-1]) & (sum[WIDTH-1] != s1_x[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_f     <= 1'b0;
         s1_no    <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_x     <= x_pre;
         s1_y     <= y_pre;
         s1_f     <= f;
         s1_no    <= no;
      end else if (advance) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         zr        <= 1'b0;
         ng        <= 1'b0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (advance) begin
         out_valid <= 1'b1;
         out       <= res;
         zr        <= (res == '0);
         ng        <= res[WIDTH-1];
         cout      <= res_cout;
         ovf       <= res_ovf;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/hack_alu_pipe.md
Name: hack_alu_pipe

Overview:
- Parametrised, 2-stage pipelined successor of the team's combinational Hack ALU.
- Keeps the six Hack control bits (zx, nx, zy, ny, f, no) and their exact semantics.
- Adds configurable width, a valid/ready handshake with full backpressure, and registered status flags: zr, ng, cout, ovf.
- Sits between the decode stage and the register writeback in the CPU datapath.
- Accepts one operation per cycle.

Parameters:
WIDTH, 16, data width of a, b, out (legal range ≥ 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation presented on a, b and the control bits
in_ready  output  1  block accepts the operation this cycle
a  input  WIDTH  x operand
b  input  WIDTH  y operand
zx  input  1  zero x
nx  input  1  invert x (applied after zx)
zy  input  1  zero y
ny  input  1  invert y (applied after zy)
f  input  1  1: x+y, 0: x&y
no  input  1  invert result
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes the result this cycle
out  output  WIDTH  result
zr  output  1  out == 0
ng  output  1  out[WIDTH-1]
cout  output  1  carry out of the WIDTH-bit add (f=1); 0 when f=0
ovf  output  1  two's-complement overflow of the add, before no (f=1); 0 when f=0

Behaviour:
- One clock and one reset.
- Reset is synchronous and active-high.
- Reset state: s1_valid=0, out_valid=0, out=0, zr=0, ng=0, cout=0, ovf=0. Internal stage-1 data registers are cleared to 0.
- Reset mid-operation: all in-flight operations are discarded without output. in_ready=1 on the first cycle after rst deasserts.
- Stage 1 (S1), on accept (in_valid && in_ready):
  - x' = (zx ? 0 : a), then inverted if nx.
  - y' = (zy ? 0 : b), then inverted if ny.
  - Register x', y', f, no; set s1_valid=1.
- Stage 2 (S2), on advance (s1_valid && s2_ready):
  - sum = x' + y' at WIDTH+1 bits.
  - r = f ? sum[WIDTH-1:0] : (x' & y'); r inverted if no.
  - Register out=r, zr=(r==0), ng=r[WIDTH-1].
  - cout = f & sum[WIDTH].
  - ovf = f & (x'[MSB]==y'[MSB]) & (sum[MSB]!=x'[MSB]).
  - Set out_valid=1.
- Handshake:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready. This is combinational from out_ready; that path is documented and allowed.
  - S1 with no advance and no new accept: s1_valid clears if S1 drained, otherwise holds.
  - Output transfer when no S1 advance: out_valid clears.
- Latency: 2 cycles from accept to out_valid with out_ready=1. Throughput: 1 op/cycle.
- Stall (out_ready=0 while out_valid=1):
  - out, zr, ng, cout, ovf, out_valid held stable.
  - S1 holds its operation; in_ready=0 once S1 is occupied.
  - Maximum 2 operations in flight.
- Simultaneous events:
  - Output transfer, S1 advance and new accept can all occur in the same cycle; no bubble is inserted.
  - Results are delivered in acceptance order, exactly once.
- Input contract: a, b and the control bits are sampled only on accept. Values while in_valid=0 are ignored.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Test Plan:
1. WIDTH=16, x+y (zx=nx=zy=ny=no=0, f=1), a=3, b=5, out_ready=1 -> out_valid 2 cycles after accept; out=8, zr=0, ng=0, cout=0, ovf=0.
2. x−y (nx=1, f=1, no=1), a=10, b=3 -> out=7. Constant −1 (zx=nx=zy=1, ny=0, f=1, no=0) -> out=0xFFFF, ng=1. x&y (f=0), a=0x0F0F, b=0x00FF -> out=0x000F, cout=0, ovf=0.
3. Flag boundaries:
   - a=0xFFFF, b=1, add -> out=0, zr=1, cout=1, ovf=0.
   - a=0x7FFF, b=1 -> out=0x8000, ng=1, ovf=1, cout=0.
4. Backpressure: out_ready=0, issue ops A, B, C back-to-back -> A accepted and held on out, B held in S1, in_ready=0 for C. Raise out_ready -> A, B, C delivered in order on consecutive cycles, none lost or duplicated.
5. Continuous stream of 20 random ops with out_ready=1 -> one result per cycle after 2-cycle fill; every result matches the reference model.
6. Reset mid-stream with 2 ops in flight -> next cycle out_valid=0, out=0, all flags 0. Bench with WIDTH=8: a=0x80, b=0x80, add -> out=0, zr=1, cout=1, ovf=1.
